// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states and
// request-legality helpers.
package lsu_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        RD,
        LD_DATA,
        RMW_RD,
        RMW_MRG,
        WR,
        RESP
    } lsu_state_t;

    // True for the eight op codes the unit implements.
    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // True when the byte offset does not suit the access size.
    function automatic logic op_is_misaligned(input logic [3:0] op, input logic [1:0] byte_off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return byte_off[0];
            OP_LW, OP_SW:         return byte_off != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extract/extend a load lane from a memory word and
// merge a byte/halfword store into a memory word (little-endian lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    assign shamt   = {byte_off, 3'b000};
    assign shifted = rdata >> shamt;

    // Extract the addressed lane and sign- or zero-extend it.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        load_data = shifted;
        case (op)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LBU:  load_data = {24'b0, shifted[7:0]};
            OP_LHU:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Replace the addressed byte/halfword lane of the read word with store data.
    always_comb begin
        merged = rdata;
        case (op)
            OP_SB:   merged = (rdata & ~(32'h0000_00FF << shamt)) | ({24'b0, wdata[7:0]} << shamt);
            OP_SH:   merged = (rdata & ~(32'h0000_FFFF << shamt)) | ({16'b0, wdata} << shamt);
            default: merged = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, performs word loads with lane
// extraction, byte/halfword stores via read-modify-write, and returns a response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RD_OFFSET  = 10'h0F0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wr_rd,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t state, next_state;

    // Captured request
    logic [3:0]            op_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [15:0]           wdata_q;

    logic                  req_bad;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic [31:0]           load_data;
    logic [31:0]           merged;
    logic                  unused_addr_bits;

    // Address bits above the word index are deliberately ignored.
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign req_idx = req_addr[ADDR_WIDTH+1:2];
    assign req_bad = !op_is_legal(req_op) || op_is_misaligned(req_op, req_addr[1:0]);

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_wr_rd  = (state != WR);

    lsu_align u_align (
        .op        (op_q),
        .byte_off  (off_q),
        .rdata     (mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)              next_state = ERR;
                    else if (req_op == OP_SW) next_state = WR;
                    else if (req_op[3])       next_state = RMW_RD;
                    else                      next_state = RD;
                end
            end
            ERR:     next_state = RESP;
            RD:      next_state = LD_DATA;
            LD_DATA: next_state = RESP;
            RMW_RD:  next_state = RMW_MRG;
            RMW_MRG: next_state = WR;
            WR:      next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture, memory address/data and response registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here, including the captured request, is cleared by reset so
        // an interrupted transaction leaves nothing behind.
        if (rst) begin
            op_q       <= '0;
            off_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        off_q      <= req_addr[1:0];
                        idx_q      <= req_idx;
                        wdata_q    <= req_wdata[15:0];
                        resp_rdata <= '0;
                        resp_err   <= req_bad;
                        if (!req_bad) begin
                            if (req_op == OP_SW) begin
                                mem_addr  <= req_idx;
                                mem_wdata <= req_wdata;
                            end else begin
                                // Memory adds RD_OFFSET on reads; pre-subtract it.
                                mem_addr <= req_idx - RD_OFFSET;
                            end
                        end
                    end
                end
                LD_DATA: resp_rdata <= load_data;
                RMW_MRG: begin
                    mem_wdata <= merged;
                    mem_addr  <= idx_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// back-pressure and reset sequences, and randomized requests against a model.
module tb_load_store_unit;

    localparam logic [9:0] RD_OFF = 10'h0F0;
    localparam logic [3:0] LB  = 4'b0000, LH  = 4'b0001, LW = 4'b0010;
    localparam logic [3:0] LBU = 4'b0100, LHU = 4'b0101;
    localparam logic [3:0] SB  = 4'b1000, SH  = 4'b1001, SW = 4'b1010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_rd;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr_rd  (mem_wr_rd),
        .mem_rdata  (mem_rdata)
    );

    // Data memory: writes land at mem_addr, reads return mem_addr + RD_OFF one cycle later.
    always @(posedge clk) begin
        if (!mem_wr_rd) begin
            mem[mem_addr] = mem_wdata;
            wr_count = wr_count + 1;
        end else begin
            mem_rdata <= mem[mem_addr + RD_OFF];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: arithmetic on byte lanes of a word array.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat, output int writes);
        int     idx, off, size;
        bit     sgn, store;
        longint word, mask, val;
        idx = int'(addr[11:2]);
        off = int'(addr[1:0]);
        size = 0; sgn = 0; store = 0;
        case (op)
            LB:  begin size = 1; sgn = 1; end
            LH:  begin size = 2; sgn = 1; end
            LW:  size = 4;
            LBU: size = 1;
            LHU: size = 2;
            SB:  begin size = 1; store = 1; end
            SH:  begin size = 2; store = 1; end
            SW:  begin size = 4; store = 1; end
            default: size = 0;
        endcase
        rdata = '0;
        writes = 0;
        if (size == 0) err = 1'b1;
        else           err = (off % size) != 0;
        if (err) begin
            lat = 1;
        end else begin
            word = longint'(ref_mem[idx]);
            mask = (longint'(1) << (8 * size)) - 1;
            if (store) begin
                word = (word & ~(mask << (8 * off))) | ((longint'(wdata) & mask) << (8 * off));
                ref_mem[idx] = word[31:0];
                writes = 1;
                lat = (size == 4) ? 1 : 3;
            end else begin
                val = (word >> (8 * off)) & mask;
                if (sgn && val >= (mask + 1) / 2) val = val - (mask + 1);
                rdata = val[31:0];
                lat = 2;
            end
        end
    endtask

    // Issue one request with resp_ready high; measure latency and write cycles.
    task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat, output int writes);
        int w0;
        @(negedge clk);
        req_op = op; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1; resp_ready = 1'b1;
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        w0 = wr_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = n;
                break;
            end
        end
        rdata = resp_rdata;
        err = resp_err;
        @(posedge clk);
        #1;
        writes = wr_count - w0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, m_rd;
        logic        er, m_er;
        int          lat, wr, m_lat, m_wr, w0, idx, n_lat;
        logic [31:0] saved;
        logic [3:0]  op;
        logic [31:0] addr, wdata;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[5] = 32'h8877_F0A1;
        mem[0] = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst req_ready",  32'(req_ready),  32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata,      32'd0);
        check("rst resp_err",   32'(resp_err),   32'd0);
        check("rst mem_wr_rd",  32'(mem_wr_rd),  32'd1);
        check("rst mem_addr",   32'(mem_addr),   32'd0);
        check("rst mem_wdata",  mem_wdata,       32'd0);
        rst = 1'b0;

        // Directed vectors, applied in order from the known initial memory
        vecs.push_back(vec_t'{LB,  32'h0000_0014, 32'h0,         32'hFFFF_FFA1, 1'b0, 2, 0});
        vecs.push_back(vec_t'{LHU, 32'h0000_0016, 32'h0,         32'h0000_8877, 1'b0, 2, 0});
        vecs.push_back(vec_t'{LH,  32'h0000_0016, 32'h0,         32'hFFFF_8877, 1'b0, 2, 0});
        vecs.push_back(vec_t'{LBU, 32'h0000_0015, 32'h0,         32'h0000_00F0, 1'b0, 2, 0});
        vecs.push_back(vec_t'{LW,  32'h0000_0014, 32'h0,         32'h8877_F0A1, 1'b0, 2, 0});
        vecs.push_back(vec_t'{SB,  32'h0000_0015, 32'h0000_0055, 32'h0,         1'b0, 3, 1});
        vecs.push_back(vec_t'{LW,  32'h0000_0014, 32'h0,         32'h8877_55A1, 1'b0, 2, 0});
        vecs.push_back(vec_t'{LW,  32'h0000_0006, 32'h0,         32'h0,         1'b1, 1, 0});
        vecs.push_back(vec_t'{SH,  32'h0000_0017, 32'h0000_1234, 32'h0,         1'b1, 1, 0});
        vecs.push_back(vec_t'{LH,  32'h0000_0015, 32'h0,         32'h0,         1'b1, 1, 0});
        vecs.push_back(vec_t'{4'b0011, 32'h0000_0014, 32'h0,     32'h0,         1'b1, 1, 0});
        vecs.push_back(vec_t'{SH,  32'h0000_0016, 32'hAAAA_1234, 32'h0,         1'b0, 3, 1});
        vecs.push_back(vec_t'{LB,  32'h0000_0017, 32'h0,         32'h0000_0012, 1'b0, 2, 0});
        vecs.push_back(vec_t'{SW,  32'h0000_0008, 32'hCAFE_F00D, 32'h0,         1'b0, 1, 1});
        vecs.push_back(vec_t'{LW,  32'h0000_0008, 32'h0,         32'hCAFE_F00D, 1'b0, 2, 0});
        vecs.push_back(vec_t'{LW,  32'hFFFF_F014, 32'h0,         32'h1234_55A1, 1'b0, 2, 0});

        foreach (vecs[i]) begin
            model(vecs[i].op, vecs[i].addr, vecs[i].wdata, m_rd, m_er, m_lat, m_wr);
            run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, er, lat, wr);
            idx = int'(vecs[i].addr[11:2]);
            check($sformatf("vec%0d rdata", i),  rd,         vecs[i].rdata);
            check($sformatf("vec%0d err", i),    32'(er),    32'(vecs[i].err));
            check($sformatf("vec%0d lat", i),    32'(lat),   32'(vecs[i].lat));
            check($sformatf("vec%0d writes", i), 32'(wr),    32'(vecs[i].writes));
            check($sformatf("vec%0d memword", i), mem[idx], ref_mem[idx]);
        end

        // SW with response back-pressure while a second request waits
        w0 = wr_count;
        @(negedge clk);
        req_op = SW; req_addr = 32'h0; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1; resp_ready = 1'b0;
        model(SW, 32'h0, 32'hDEAD_BEEF, m_rd, m_er, m_lat, m_wr);
        @(posedge clk);
        #1 req_op = LW; req_addr = 32'h0; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp resp_valid%0d", k), 32'(resp_valid), 32'd1);
            check($sformatf("bp req_ready%0d", k),  32'(req_ready),  32'd0);
            check($sformatf("bp resp_rdata%0d", k), resp_rdata,      32'd0);
            check($sformatf("bp resp_err%0d", k),   32'(resp_err),   32'd0);
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp idle resp_valid", 32'(resp_valid), 32'd0);
        check("bp idle req_ready",  32'(req_ready),  32'd1);
        check("bp writes",          32'(wr_count - w0), 32'd1);
        check("bp mem0",            mem[0], 32'hDEAD_BEEF);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                n_lat = n;
                break;
            end
        end
        check("waiting lw lat",   32'(n_lat), 32'd2);
        check("waiting lw rdata", resp_rdata, 32'hDEAD_BEEF);
        check("waiting lw err",   32'(resp_err), 32'd0);
        @(posedge clk);
        #1;

        // Reset during RMW_MRG of an SH: no write, clean idle afterwards
        w0 = wr_count;
        saved = mem[5];
        @(negedge clk);
        req_op = SH; req_addr = 32'h14; req_wdata = 32'h0000_7777;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid resp_valid", 32'(resp_valid), 32'd0);
        check("rstmid mem_wr_rd",  32'(mem_wr_rd),  32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid writes",     32'(wr_count - w0), 32'd0);
        check("rstmid mem5",       mem[5], saved);
        check("rstmid resp_valid after", 32'(resp_valid), 32'd0);
        check("rstmid req_ready",  32'(req_ready), 32'd1);
        check("rstmid resp_rdata", resp_rdata, 32'd0);

        // Randomized requests against the reference model
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 8))
                0: op = LB;
                1: op = LH;
                2: op = LW;
                3: op = LBU;
                4: op = LHU;
                5: op = SB;
                6: op = SH;
                7: op = SW;
                default: op = 4'($urandom);
            endcase
            addr  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            wdata = $urandom;
            model(op, addr, wdata, m_rd, m_er, m_lat, m_wr);
            run_req(op, addr, wdata, rd, er, lat, wr);
            idx = int'(addr[11:2]);
            check($sformatf("rnd%0d op%h rdata", t, op), rd, m_rd);
            check($sformatf("rnd%0d op%h err", t, op),   32'(er),  32'(m_er));
            check($sformatf("rnd%0d op%h lat", t, op),   32'(lat), 32'(m_lat));
            check($sformatf("rnd%0d op%h writes", t, op), 32'(wr), 32'(m_wr));
            check($sformatf("rnd%0d memword", t), mem[idx], ref_mem[idx]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, 32, memory word width; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, 10, memory word-address width.
REQ-003 Parameter RD_OFFSET, 10'h0F0, fixed offset the data memory adds to every read address.
REQ-004 clk  input  1  clock, rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  unit can accept a request.
REQ-008 req_op  input  4  0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  consumer accepts the response.
REQ-013 resp_rdata  output  32  load result (0 for stores and errors).
REQ-014 resp_err  output  1  misaligned or illegal op.
REQ-015 mem_addr  output  ADDR_WIDTH  data-memory word address.
REQ-016 mem_wdata  output  32  data-memory write data.
REQ-017 mem_wr_rd  output  1  0 = write, 1 = read.
REQ-018 mem_rdata  input  32  data-memory read data, valid in the cycle after a read address is presented.

Function
REQ-019 The unit SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid and req_ready both high.
REQ-020 The word index SHALL be req_addr[ADDR_WIDTH+1:2]; req_addr bits above ADDR_WIDTH+1 SHALL be ignored.
REQ-021 Byte lanes SHALL be little-endian: byte k occupies bits 8k+7:8k.
REQ-022 LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, or an unlisted op SHALL go IDLE->ERR->RESP with resp_err=1, and no memory write.
REQ-023 The FSM states SHALL be IDLE, ERR, RD, LD_DATA, RMW_RD, RMW_MRG, WR, RESP.
REQ-024 Loads SHALL take IDLE->RD->LD_DATA->RESP. Stores: SW IDLE->WR->RESP; SB/SH IDLE->RMW_RD->RMW_MRG->WR->RESP.
REQ-025 In RD and RMW_RD: mem_wr_rd=1 and mem_addr=(word index - RD_OFFSET) mod 2^ADDR_WIDTH, so the read returns the requested word.
REQ-026 In LD_DATA the unit SHALL register the extracted lane into resp_rdata: sign-extended for LB/LH, zero-extended for LBU/LHU, whole word for LW.
REQ-027 In RMW_MRG the unit SHALL replace the addressed byte/halfword lane of mem_rdata with req_wdata[7:0]/[15:0] and register the result as mem_wdata.
REQ-028 In WR: mem_wr_rd=0, mem_addr=word index, mem_wdata=full word (SW) or merged word; this is the only state with mem_wr_rd=0.
REQ-029 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL hold stable until resp_ready is high at a rising edge; the FSM then returns to IDLE.
REQ-030 Response latency with resp_ready held high, counted from the acceptance edge T: error T+1, SW T+1, loads T+2, SB/SH T+3.
REQ-031 Outside WR, mem_addr SHALL hold its last value and mem_wr_rd SHALL be 1.
REQ-032 A request arriving while the unit is busy SHALL wait; it is never dropped and never accepted.

Reset
REQ-033 On rst: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_wr_rd=1, mem_addr=0, mem_wdata=0; captured request cleared.
REQ-034 rst asserted before the WR rising edge SHALL prevent the memory write; no partial response appears after reset.

Structure
REQ-035 Package lsu_pkg SHALL hold the op-code constants and the FSM state typedef.
REQ-036 Sub-module lsu_align SHALL implement combinational lane extract/extend and lane merge; the FSM and registers stay in load_store_unit.

Verification
REQ-037 Bench memory word 5 = 32'h8877_F0A1; LB addr 0x14 -> rdata 32'hFFFF_FFA1, err=0, resp at T+2.
REQ-038 Same word; LHU addr 0x16 -> 32'h0000_8877; LH addr 0x16 -> 32'hFFFF_8877.
REQ-039 SB addr 0x15, wdata 0x55 -> word 5 becomes 32'h8877_55A1; exactly one write cycle; resp at T+3.
REQ-040 LW addr 0x06 -> resp_err=1 at T+1; no write cycle; memory unchanged.
REQ-041 SW addr 0x0, wdata 32'hDEAD_BEEF with resp_ready held low for 3 cycles -> resp_valid held, no second request accepted, then return to IDLE.
REQ-042 rst pulsed in RMW_MRG of an SH -> no write to memory, resp_valid=0, req_ready=1 after release.
